// File: rtl/path_rom_reader.sv
// -----------------------------------------------------------------------------
// path_rom_reader
//
// Consumer end of the enemy path pipeline. Once per frame it samples the path
// address from addres_gen, fetches the word at that address from the
// synchronous path ROM, and decodes it into clamped screen coordinates.
// A path word is {dx[7:0], dy[7:0]}. The word 16'hFFFF marks the end of the
// path: it raises path_end instead of updating the position.
//
// Ports (all logic in the pclk domain):
//   pclk        in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   address_in  in  12   current path address from addres_gen
//   level       in   2   current game level, 0..3
//   frame_tick  in   1   one-cycle pulse per frame, starts a fetch from IDLE
//   rom_addr    out 12   registered path ROM address, held between fetches
//   rom_data    in  16   ROM word, valid one cycle after rom_addr is sampled
//   xpos        out 11   decoded x position, clamped to X_MAX
//   ypos        out 11   decoded y position, clamped to Y_MAX
//   pos_valid   out  1   one-cycle pulse when xpos/ypos update
//   path_end    out  1   one-cycle pulse when the sentinel word is read
//   busy        out  1   high while a fetch is in progress
//
// A tick in cycle T gives rom_addr at T+1, busy over T+1..T+3, and the new
// position (or path_end) together with busy=0 in T+4. Ticks outside IDLE are
// dropped, not queued.
// -----------------------------------------------------------------------------
module path_rom_reader #(
  parameter int X_BASE       = 32,
  parameter int Y_BASE       = 16,
  parameter int LEVEL_Y_STEP = 24,
  parameter int X_MAX        = 767,
  parameter int Y_MAX        = 575
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] address_in,
  input  logic [1:0]  level,
  input  logic        frame_tick,
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        pos_valid,
  output logic        path_end,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE
  } state_t;

  localparam logic [11:0] XBASE_W  = 12'(X_BASE);
  localparam logic [11:0] YBASE_W  = 12'(Y_BASE);
  localparam logic [11:0] YSTEP_W  = 12'(LEVEL_Y_STEP);
  localparam logic [11:0] XMAX_W   = 12'(X_MAX);
  localparam logic [11:0] YMAX_W   = 12'(Y_MAX);
  localparam logic [15:0] SENTINEL = 16'hFFFF;

  state_t      state;
  logic [1:0]  lvl_q;
  logic [15:0] data_q;

  logic [11:0] x_full;
  logic [11:0] y_full;
  logic [11:0] x_clamp;
  logic [11:0] y_clamp;

  // Decode of the registered ROM word. All sums are 12 bits unsigned; with
  // the default parameters the largest x is 32 + 1020 = 1052, which still
  // fits, so the clamp sees the true value.
  // NOTE: every signal driven here gets a value on every path, otherwise the
  // synthesiser infers a latch to hold the old value.
  always_comb begin
    x_full  = XBASE_W + {2'b00, data_q[15:8], 2'b00};
    y_full  = YBASE_W + {4'b0000, data_q[7:0]} + (YSTEP_W * {10'd0, lvl_q});
    x_clamp = (x_full > XMAX_W) ? XMAX_W : x_full;
    y_clamp = (y_full > YMAX_W) ? YMAX_W : y_full;
  end

  // Single FSM block with registered outputs. pos_valid and path_end default
  // low every cycle so each can only be a one-cycle pulse out of DECODE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: data_q and lvl_q are plain registers, not a memory, so resetting
  // them along with the outputs costs nothing and keeps the state defined.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      lvl_q     <= '0;
      data_q    <= '0;
      xpos      <= '0;
      ypos      <= '0;
      pos_valid <= 1'b0;
      path_end  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      path_end  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            rom_addr <= address_in;
            lvl_q    <= level;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        // The ROM samples rom_addr at the end of this cycle.
        FETCH: state <= WAIT;
        WAIT: begin
          data_q <= rom_data;
          state  <= DECODE;
        end
        DECODE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (data_q == SENTINEL) begin
            path_end <= 1'b1;
          end else begin
            xpos      <= x_clamp[10:0];
            ypos      <= y_clamp[10:0];
            pos_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_path_rom_reader
//
// Directed and randomized bench for path_rom_reader. A synchronous ROM model
// sits on rom_addr/rom_data. Expected positions come from the coordinate rules
// in plain integer arithmetic; expected timing comes from the fixed 4-cycle
// tick-to-result latency.
// -----------------------------------------------------------------------------
module tb_path_rom_reader;

  localparam int XB = 32;
  localparam int YB = 16;
  localparam int YS = 24;
  localparam int XM = 767;
  localparam int YM = 575;

  logic        pclk;
  logic        rst;
  logic [11:0] address_in;
  logic [1:0]  level;
  logic        frame_tick;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        pos_valid;
  logic        path_end;
  logic        busy;

  logic [15:0] rom [4096];

  int n_cmp = 0;
  int n_err = 0;

  // Reference position, carried across sentinel words and cleared by reset.
  int exp_x = 0;
  int exp_y = 0;

  path_rom_reader dut (
    .pclk       (pclk),
    .rst        (rst),
    .address_in (address_in),
    .level      (level),
    .frame_tick (frame_tick),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .xpos       (xpos),
    .ypos       (ypos),
    .pos_valid  (pos_valid),
    .path_end   (path_end),
    .busy       (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Synchronous ROM: word for the address sampled at an edge appears after it.
  always @(posedge pclk) rom_data <= rom[rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: inputs are driven and outputs
  // sampled at this point, well away from the edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Reference decode: updates exp_x/exp_y, returns 1 for the sentinel.
  function automatic bit model(input logic [15:0] w, input int lvl);
    int x;
    int y;
    if (w == 16'hFFFF) return 1'b1;
    x = XB + 4 * int'(w[15:8]);
    y = YB + int'(w[7:0]) + YS * lvl;
    exp_x = (x > XM) ? XM : x;
    exp_y = (y > YM) ? YM : y;
    return 1'b0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pos_valid"}, 32'(pos_valid), 0);
    check({tag, "_path_end"},  32'(path_end),  0);
    check({tag, "_busy"},      32'(busy),      0);
  endtask

  // Full fetch from cycle T (current cycle, DUT in IDLE) through T+5.
  // address_in and level are scrambled once the tick has been sampled.
  task automatic do_fetch(input string tag, input logic [11:0] addr,
                          input logic [1:0] lvl, input logic [15:0] word);
    bit sent;
    rom[addr]  = word;
    address_in = addr;
    level      = lvl;
    frame_tick = 1'b1;
    sent = model(word, int'(lvl));
    step();                                   // T+1
    frame_tick = 1'b0;
    address_in = 12'($urandom);
    level      = 2'($urandom);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'(addr));
    check({tag, "_busy1"},    32'(busy),     1);
    step();                                   // T+2
    check({tag, "_busy2"},    32'(busy),     1);
    step();                                   // T+3
    check({tag, "_busy3"},    32'(busy),     1);
    check({tag, "_early"},    32'(pos_valid | path_end), 0);
    step();                                   // T+4
    check({tag, "_busy4"},    32'(busy),      0);
    check({tag, "_pos_valid"},32'(pos_valid), 32'(!sent));
    check({tag, "_path_end"}, 32'(path_end),  32'(sent));
    check({tag, "_xpos"},     32'(xpos),      32'(exp_x));
    check({tag, "_ypos"},     32'(ypos),      32'(exp_y));
    step();                                   // T+5
    check({tag, "_pulse_end"},32'(pos_valid | path_end), 0);
    check({tag, "_hold_addr"},32'(rom_addr),  32'(addr));
  endtask

  initial begin
    int pulses;
    bit dummy;
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    rst        = 1'b1;
    address_in = '0;
    level      = '0;
    frame_tick = 1'b0;

    // Reset held for 50 ns.
    #50;
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_xpos",     32'(xpos), 0);
    check("rst_ypos",     32'(ypos), 0);
    check_idle_outputs("rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle_outputs("post_rst");
    end

    // Directed decode cases.
    do_fetch("basic", 12'h005, 2'd0, 16'h1008);      // 96, 24
    do_fetch("clamp_x", 12'h123, 2'd3, 16'hFF40);    // 767, 152
    do_fetch("max_y", 12'h124, 2'd3, 16'h00FF);      // 32, 343
    do_fetch("sentinel", 12'h125, 2'd1, 16'hFFFF);   // hold 32, 343

    // Overlap: second tick two cycles in is dropped; address change at T+1
    // must not reach rom_addr.
    rom[12'h200] = 16'h2010;
    address_in   = 12'h200;
    level        = 2'd2;
    frame_tick   = 1'b1;
    dummy = model(16'h2010, 2);                      // 160, 80
    step();                                          // T+1
    frame_tick = 1'b0;
    address_in = 12'h3AB;
    check("ovl_rom_addr", 32'(rom_addr), 32'h200);
    step();                                          // T+2
    frame_tick = 1'b1;
    step();                                          // T+3
    frame_tick = 1'b0;
    step();                                          // T+4
    check("ovl_pos_valid", 32'(pos_valid), 1);
    check("ovl_xpos", 32'(xpos), 32'(exp_x));
    check("ovl_ypos", 32'(ypos), 32'(exp_y));
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle_outputs("ovl_no_second");
      check("ovl_hold_addr", 32'(rom_addr), 32'h200);
    end

    // Tick held high for 12 cycles: fetches accepted at T, T+4, T+8.
    rom[12'h010] = 16'h0102;
    address_in   = 12'h010;
    level        = 2'd1;
    dummy = model(16'h0102, 1);                      // 36, 42
    pulses = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 12) frame_tick = 1'b0;
      if (pos_valid) pulses++;
      check("held_no_both", 32'(pos_valid & path_end), 0);
      step();
    end
    check("held_pulses", 32'(pulses), 3);
    check("held_xpos", 32'(xpos), 32'(exp_x));
    check("held_ypos", 32'(ypos), 32'(exp_y));

    // Reset pulsed while in WAIT aborts the fetch.
    rom[12'h300] = 16'h4040;
    address_in   = 12'h300;
    level        = 2'd0;
    frame_tick   = 1'b1;
    step();                                          // T+1
    frame_tick = 1'b0;
    step();                                          // T+2, WAIT
    #2;
    rst = 1'b1;
    #1;
    exp_x = 0;
    exp_y = 0;
    check("mid_rst_rom_addr", 32'(rom_addr), 0);
    check("mid_rst_xpos", 32'(xpos), 0);
    check("mid_rst_ypos", 32'(ypos), 0);
    check_idle_outputs("mid_rst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle_outputs("after_abort");
    end
    do_fetch("post_abort", 12'h300, 2'd0, 16'h4040); // 288, 80

    // Randomized fetches with occasional sentinels.
    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      logic [15:0] w;
      a = 12'($urandom);
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w = 16'hFFFF;
      do_fetch("rand", a, 2'($urandom), w);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/path_rom_reader.md
# path_rom_reader

Consumer end of the address-generator path: once per frame it samples the 12-bit path address produced by `addres_gen`, fetches the corresponding word from the synchronous enemy-path ROM, and decodes it into clamped screen coordinates for the enemy drawing stage. The word format is 16 bits: dx in [15:8], dy in [7:0]. It also detects the end-of-path sentinel. It sits between `addres_gen` / path ROM and the enemy draw/control logic, all in the `pclk` domain.

## Interface
Parameters:
- `X_BASE`, 32, x origin of path (pixels)
- `Y_BASE`, 16, y origin of path (pixels)
- `LEVEL_Y_STEP`, 24, extra y offset per level
- `X_MAX`, 767, largest legal xpos
- `Y_MAX`, 575, largest legal ypos

Ports:
- `pclk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `address_in`  in  12  current path address from `addres_gen`
- `level`  in  2  current game level, 0..3
- `frame_tick`  in  1  one-cycle pulse per frame, starts a fetch
- `rom_addr`  out  12  registered address to path ROM
- `rom_data`  in  16  ROM output, valid one cycle after `rom_addr` is sampled
- `xpos`  out  11  decoded x position
- `ypos`  out  11  decoded y position
- `pos_valid`  out  1  one-cycle pulse when `xpos`/`ypos` are updated
- `path_end`  out  1  one-cycle pulse when the sentinel word is read
- `busy`  out  1  high while a fetch is in progress

## Operation
- FSM states: IDLE, FETCH, WAIT, DECODE.
- IDLE, `frame_tick`=1: register `rom_addr` <= `address_in` and `lvl_q` <= `level`, then go to FETCH. Without `frame_tick`, stay in IDLE.
- FETCH → WAIT unconditionally. This is the cycle in which the ROM samples `rom_addr`.
- WAIT → DECODE unconditionally. `rom_data` is valid during WAIT and is registered into `data_q`.
- DECODE → IDLE. It performs the decode from `data_q`:
  - `data_q` = 16'hFFFF is the sentinel: `xpos`/`ypos` hold, `path_end` pulses, `pos_valid` stays 0.
  - Otherwise: `x` = X_BASE + {dx,2'b00} and `y` = Y_BASE + dy + `lvl_q`*LEVEL_Y_STEP, both computed 12 bits wide and unsigned.
  - `xpos` = min(`x`, X_MAX) and `ypos` = min(`y`, Y_MAX), truncated to 11 bits after the clamp.
  - `pos_valid` pulses.
- `busy` = 1 in FETCH, WAIT and DECODE; 0 in IDLE.
- `frame_tick` outside IDLE is ignored. It is not queued.
- `level` and `address_in` changes after the sampling cycle have no effect on the fetch in flight.
- `rom_addr` holds its value between fetches.

## Timing
- Reset values: `rom_addr`=0, `xpos`=0, `ypos`=0, `pos_valid`=0, `path_end`=0, `busy`=0, state IDLE.
- `frame_tick` is high in cycle T (IDLE):
  - `rom_addr` updates at T+1 and `busy`=1 from T+1 through T+3.
  - `rom_data` is sampled at the end of T+2.
  - New `xpos`/`ypos` plus the `pos_valid` (or `path_end`) pulse are visible in T+4, with `busy`=0 in T+4.
- Latency from tick to valid is 4 cycles. The fetch rate is at most one per 4 cycles, and a tick in T+4 is accepted.
- `pos_valid` and `path_end` are never high in the same cycle. Each is exactly one cycle wide.
- Reset asserted mid-fetch:
  - All outputs go immediately to their reset values and the FSM goes to IDLE.
  - No `pos_valid` is produced for the aborted fetch.
  - After release, the first fetch needs a new `frame_tick`.
- `frame_tick` held high continuously produces a fetch every 4 cycles, with IDLE for 1 cycle between fetches.

## Test plan
- Reset: assert `rst` for 50 ns → all outputs 0, `busy`=0; no pulses until a `frame_tick`.
- Basic fetch: `address_in`=12'h005, `level`=0, ROM[5]=16'h1008, tick at T → `rom_addr`=5 at T+1; at T+4 `xpos`=96, `ypos`=24, `pos_valid`=1 for one cycle.
- Level offset and clamp:
  - `level`=3, ROM word 16'hFF40 → `xpos`=767 (1052 clamped), `ypos`=16+64+72=152.
  - ROM word 16'h00FF at `level`=3 → `ypos`=343.
- Sentinel: ROM word 16'hFFFF after a valid fetch → `path_end`=1 for one cycle, `pos_valid`=0, `xpos`/`ypos` unchanged.
- Overlap and hold: tick at T and T+2 → only one fetch. `address_in` changed at T+1 → `rom_addr` keeps the T value. Tick held high for 12 cycles → exactly 3 `pos_valid` pulses.
- Reset mid-fetch: `rst` pulsed in WAIT → no `pos_valid`, outputs 0; the next tick completes a normal 4-cycle fetch.
